// File: rtl/lock_digit_entry.sv
// ============================================================================
// Module : lock_digit_entry
// Brief  : Synchronises and debounces the lock keypad, captures one digit per
//          enter press and offers it to the lock FSM over valid/ready.
//          Optional range check: define LOCK_DIGIT_RANGE_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_DIGITS      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       clear_pulse,
    output logic [2:0] entry_count,
    output logic       entry_full,
    output logic       digit_err
);

    localparam int         CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [2:0] C_MAX = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_OFFER        = 2'd1,
        S_WAIT_RELEASE = 2'd2
    } state_t;

    logic [3:0] r_sw_s1, r_sw_s2;
    logic [1:0] r_key_s1, r_key_s2;   // [0] enter, [1] clear
    logic [1:0] w_press;
    logic       w_enter_level;
    logic       w_sw_bad;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_digit_out, w_digit_out_nxt;
    logic       r_digit_valid, w_digit_valid_nxt;
    logic [2:0] r_entry_count, w_entry_count_nxt;
    logic       r_clear_pulse, w_clear_pulse_nxt;
    logic       r_digit_err, w_digit_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1  <= 4'd0;
            r_sw_s2  <= 4'd0;
            r_key_s1 <= 2'b11;
            r_key_s2 <= 2'b11;
        end else begin
            r_sw_s1  <= sw_in;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= {key_clear_n, key_enter_n};
            r_key_s2 <= r_key_s1;
        end
    end

    generate
        for (genvar k = 0; k < 2; k++) begin : g_debounce
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             w_flip;

            // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample.
            assign w_flip     = (r_key_s2[k] != r_level) &&
                                (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
            assign w_press[k] = w_flip & ~r_key_s2[k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_level <= 1'b1;
                end else if (r_key_s2[k] == r_level) begin
                    r_cnt   <= '0;
                end else if (w_flip) begin
                    r_cnt   <= '0;
                    r_level <= r_key_s2[k];
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            if (k == 0) begin : g_enter_level
                assign w_enter_level = r_level;
            end
        end
    endgenerate

`ifdef LOCK_DIGIT_RANGE_CHECK_EN
    assign w_sw_bad = (r_sw_s2 > 4'd9);
`else
    assign w_sw_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_digit_out   <= 4'd0;
            r_digit_valid <= 1'b0;
            r_entry_count <= 3'd0;
            r_clear_pulse <= 1'b0;
            r_digit_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_digit_out   <= w_digit_out_nxt;
            r_digit_valid <= w_digit_valid_nxt;
            r_entry_count <= w_entry_count_nxt;
            r_clear_pulse <= w_clear_pulse_nxt;
            r_digit_err   <= w_digit_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_digit_out_nxt   = r_digit_out;
        w_digit_valid_nxt = r_digit_valid;
        w_entry_count_nxt = r_entry_count;
        w_clear_pulse_nxt = 1'b0;
        w_digit_err_nxt   = 1'b0;

        // Clear has priority over any enter press or handshake in the same cycle.
        if (w_press[1]) begin
            w_clear_pulse_nxt = 1'b1;
            w_entry_count_nxt = 3'd0;
            w_digit_valid_nxt = 1'b0;
            w_state_nxt       = w_enter_level ? S_IDLE : S_WAIT_RELEASE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press[0]) begin
                        w_state_nxt = S_WAIT_RELEASE;
                        if (!entry_full) begin
                            if (w_sw_bad) begin
                                w_digit_err_nxt = 1'b1;
                            end else begin
                                w_digit_out_nxt   = r_sw_s2;
                                w_digit_valid_nxt = 1'b1;
                                w_state_nxt       = S_OFFER;
                            end
                        end
                    end
                end
                S_OFFER: begin
                    if (r_digit_valid && digit_ready) begin
                        if (r_entry_count != C_MAX) begin
                            w_entry_count_nxt = r_entry_count + 3'd1;
                        end
                        w_digit_valid_nxt = 1'b0;
                        w_state_nxt       = S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (w_enter_level) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign digit_out   = r_digit_out;
    assign digit_valid = r_digit_valid;
    assign entry_count = r_entry_count;
    assign entry_full  = (r_entry_count == C_MAX);
    assign clear_pulse = r_clear_pulse;
    assign digit_err   = r_digit_err;

endmodule

`default_nettype wire

// File: tb/tb_lock_digit_entry.sv
// ============================================================================
// Module : tb_lock_digit_entry
// Brief  : Directed self-checking bench for lock_digit_entry (DEBOUNCE_CYCLES=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_digit_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_in;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       digit_ready;
    logic       clear_pulse;
    logic [2:0] entry_count;
    logic       entry_full;
    logic       digit_err;

    int n_pass  = 0;
    int n_total = 0;
    int vcount  = 0;
    int ccount  = 0;
    int ecount  = 0;
    logic [3:0] last_digit = 4'd0;

    lock_digit_entry #(
        .DEBOUNCE_CYCLES (4),
        .MAX_DIGITS      (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .clear_pulse (clear_pulse),
        .entry_count (entry_count),
        .entry_full  (entry_full),
        .digit_err   (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (digit_valid) begin
                vcount++;
                last_digit = digit_out;
            end
            if (clear_pulse) ccount++;
            if (digit_err)   ecount++;
        end
    endtask

    task automatic press_release(input logic [3:0] sw);
        vcount = 0;
        ccount = 0;
        ecount = 0;
        sw_in       = sw;
        key_enter_n = 1'b0;
        run(10);
        key_enter_n = 1'b1;
        run(10);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!digit_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(digit_valid), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        sw_in       = 4'd0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        digit_ready = 1'b1;
        #3;
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_count", 32'(entry_count), 32'd0);
        check("rst_full",  32'(entry_full),  32'd0);
        check("rst_dout",  32'(digit_out),   32'd0);
        #20;
        rst_n = 1'b1;
        run(3);

        // Basic press: valid appears 6 cycles after the raw edge, for one cycle.
        sw_in       = 4'd6;
        key_enter_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t1_valid_early", 32'(digit_valid), 32'd0);
        tick();
        check("t1_valid_rise", 32'(digit_valid), 32'd1);
        check("t1_dout",       32'(digit_out),   32'd6);
        check("t1_count_pre",  32'(entry_count), 32'd0);
        tick();
        check("t1_valid_fall", 32'(digit_valid), 32'd0);
        check("t1_count",      32'(entry_count), 32'd1);
        key_enter_n = 1'b1;
        run(10);

        // Bounce: a 3-cycle glitch must not produce a digit.
        vcount      = 0;
        sw_in       = 4'd1;
        key_enter_n = 1'b0;
        run(3);
        key_enter_n = 1'b1;
        run(3);
        check("t2_glitch", 32'(vcount), 32'd0);
        key_enter_n = 1'b0;
        run(10);
        key_enter_n = 1'b1;
        run(10);
        check("t2_vcount", 32'(vcount),      32'd1);
        check("t2_digit",  32'(last_digit),  32'd1);
        check("t2_count",  32'(entry_count), 32'd2);

        // Back-pressure: digit held while ready is low and switches change.
        digit_ready = 1'b0;
        sw_in       = 4'd6;
        key_enter_n = 1'b0;
        wait_valid(12);
        sw_in = 4'd3;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(digit_valid), 32'd1);
            check("t3_hold_dout",  32'(digit_out),   32'd6);
            check("t3_hold_count", 32'(entry_count), 32'd2);
            tick();
        end
        check("t3_last_valid", 32'(digit_valid), 32'd1);
        check("t3_last_dout",  32'(digit_out),   32'd6);
        digit_ready = 1'b1;
        tick();
        check("t3_drop",  32'(digit_valid), 32'd0);
        check("t3_count", 32'(entry_count), 32'd3);
        key_enter_n = 1'b1;
        run(10);

        // Fill to six digits, then a seventh press is ignored.
        press_release(4'd3);
        check("t4_d3", 32'(last_digit), 32'd3);
        press_release(4'd7);
        check("t4_d7", 32'(last_digit), 32'd7);
        press_release(4'd1);
        check("t4_d1", 32'(vcount), 32'd1);
        check("t4_count", 32'(entry_count), 32'd6);
        check("t4_full",  32'(entry_full),  32'd1);
        press_release(4'd2);
        check("t4_seventh_valid", 32'(vcount),      32'd0);
        check("t4_seventh_count", 32'(entry_count), 32'd6);

        // Clear from full.
        ccount      = 0;
        key_clear_n = 1'b0;
        run(10);
        key_clear_n = 1'b1;
        run(10);
        check("t5_clear_pulses", 32'(ccount),      32'd1);
        check("t5_clear_count",  32'(entry_count), 32'd0);
        check("t5_clear_full",   32'(entry_full),  32'd0);

        // Clear during an offer with ready low drops the digit.
        digit_ready = 1'b0;
        sw_in       = 4'd5;
        key_enter_n = 1'b0;
        wait_valid(12);
        check("t5_offer_dout", 32'(digit_out), 32'd5);
        key_clear_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t5_pre_valid", 32'(digit_valid), 32'd1);
        check("t5_pre_pulse", 32'(clear_pulse), 32'd0);
        tick();
        check("t5_pulse",       32'(clear_pulse), 32'd1);
        check("t5_valid_drop",  32'(digit_valid), 32'd0);
        check("t5_count_zero",  32'(entry_count), 32'd0);
        tick();
        check("t5_pulse_end",   32'(clear_pulse), 32'd0);
        check("t5_valid_stays", 32'(digit_valid), 32'd0);
        key_clear_n = 1'b1;
        key_enter_n = 1'b1;
        digit_ready = 1'b1;
        run(10);

        // Out-of-range digit.
        press_release(4'd12);
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
        check("t6_err",   32'(ecount),      32'd1);
        check("t6_valid", 32'(vcount),      32'd0);
        check("t6_count", 32'(entry_count), 32'd0);
`else
        check("t6_err",   32'(ecount),      32'd0);
        check("t6_valid", 32'(vcount),      32'd1);
        check("t6_digit", 32'(last_digit),  32'd12);
        check("t6_count", 32'(entry_count), 32'd1);
`endif

        // Asynchronous reset in the middle of an offer.
        digit_ready = 1'b0;
        sw_in       = 4'd9;
        key_enter_n = 1'b0;
        wait_valid(12);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_valid", 32'(digit_valid), 32'd0);
        check("t7_dout",  32'(digit_out),   32'd0);
        check("t7_count", 32'(entry_count), 32'd0);
        check("t7_full",  32'(entry_full),  32'd0);
        check("t7_pulse", 32'(clear_pulse), 32'd0);
        check("t7_err",   32'(digit_err),   32'd0);
        key_enter_n = 1'b1;
        digit_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        run(12);
        check("t7_after_valid", 32'(digit_valid), 32'd0);
        check("t7_after_count", 32'(entry_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
